// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment reader.
// Glyphs are active-low, ordered g,f,e,d,c,b,a from MSB to LSB.
package seg7_pkg;

  localparam int SEG7_WORD_W     = 14;
  localparam int SEG7_VAL_W      = 7;
  localparam int SEG7_CONV_STEPS = 4;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'b1000000;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'b1111001;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'b0100100;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'b0110000;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'b0011001;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'b0010010;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'b0000010;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'b1111000;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'b0011000;
  localparam logic [6:0] SEG7_BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    CONVERT,
    DONE
  } seg7_rd_state_t;

endpackage

// File: rtl/seg7_reader_if.sv
// Handshake bundle for seg7_reader: display word in, decoded value out.
// slave is the reader's view, master is the producer/consumer's view.
interface seg7_reader_if;
  import seg7_pkg::*;

  logic [SEG7_WORD_W-1:0] in_word;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEG7_VAL_W-1:0]  out_value;
  logic [3:0]             out_tens;
  logic [3:0]             out_units;
  logic                   out_err;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_value, out_tens, out_units, out_err, out_valid
  );

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_value, out_tens, out_units, out_err, out_valid
  );

endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational glyph-to-BCD decode for one active-low seven-segment digit.
// allow_blank makes the all-off pattern read as 0 instead of illegal.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       allow_blank,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (pattern)
      SEG7_GLYPH_0: bcd = 4'd0;
      SEG7_GLYPH_1: bcd = 4'd1;
      SEG7_GLYPH_2: bcd = 4'd2;
      SEG7_GLYPH_3: bcd = 4'd3;
      SEG7_GLYPH_4: bcd = 4'd4;
      SEG7_GLYPH_5: bcd = 4'd5;
      SEG7_GLYPH_6: bcd = 4'd6;
      SEG7_GLYPH_7: bcd = 4'd7;
      SEG7_GLYPH_8: bcd = 4'd8;
      SEG7_GLYPH_9: bcd = 4'd9;
      SEG7_BLANK:   legal = allow_blank;
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Two-digit seven-segment reader: glyph decode, then 4-step shift-add to binary.
// Option SEG7_READER_BLANK_TENS_EN: an all-off tens digit reads as 0.
module seg7_reader
  import seg7_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  seg7_reader_if.slave bus
);

  seg7_rd_state_t         state;
  logic [SEG7_WORD_W-1:0] word_p0;
  logic [3:0]             tens_dec, units_dec;
  logic                   tens_ok, units_ok;
  logic [SEG7_VAL_W-1:0]  acc_p1;
  logic [SEG7_VAL_W-1:0]  value_r;
  logic [3:0]             tens_r, units_r;
  logic                   err_r, vld_r;
  logic [1:0]             step;
  logic                   tens_blank_ok;

  // Weight of tens bit idx is 10<<idx; the largest (80) still fits in 7 bits.
  function automatic logic [SEG7_VAL_W-1:0] step_addend(input logic [3:0] tens,
                                                        input logic [1:0] idx);
    return tens[idx] ? (SEG7_VAL_W'(10) << idx) : '0;
  endfunction

`ifdef SEG7_READER_BLANK_TENS_EN
  assign tens_blank_ok = 1'b1;
`else
  assign tens_blank_ok = 1'b0;
`endif

  seg7_digit_decode u_tens (
    .pattern     (word_p0[13:7]),
    .allow_blank (tens_blank_ok),
    .bcd         (tens_dec),
    .legal       (tens_ok)
  );

  seg7_digit_decode u_units (
    .pattern     (word_p0[6:0]),
    .allow_blank (1'b0),
    .bcd         (units_dec),
    .legal       (units_ok)
  );

  // Stage p0: capture the word on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid)
      word_p0 <= bus.in_word;
  end

  // Stage p1: decode, shift-add convert, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld_r   <= 1'b0;
      err_r   <= 1'b0;
      value_r <= '0;
      tens_r  <= '0;
      units_r <= '0;
      acc_p1  <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid)
            state <= DECODE;
        end
        DECODE: begin
          if (tens_ok && units_ok) begin
            tens_r  <= tens_dec;
            units_r <= units_dec;
            err_r   <= 1'b0;
            acc_p1  <= {3'b000, units_dec};
            step    <= '0;
            state   <= CONVERT;
          end else begin
            tens_r  <= '0;
            units_r <= '0;
            err_r   <= 1'b1;
            value_r <= '0;
            vld_r   <= 1'b1;
            state   <= DONE;
          end
        end
        CONVERT: begin
          acc_p1 <= acc_p1 + step_addend(tens_r, step);
          step   <= step + 2'd1;
          if (step == 2'(SEG7_CONV_STEPS - 1)) begin
            value_r <= acc_p1 + step_addend(tens_r, step);
            vld_r   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_r <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld_r;
  assign bus.out_err   = err_r;
  assign bus.out_value = value_r;
  assign bus.out_tens  = tens_r;
  assign bus.out_units = units_r;

endmodule
